add64_slice_sequencer: RTL and testbench
========================================

// Module: add64_slice_sequencer
// PURPOSE
//  Multi-cycle 64-bit add/subtract controller that time-shares one external
//  16-bit ripple adder slice (FullAdder16-style: A,B,Cin -> S,Cout, purely
//  combinational). Accepts one operation over a valid/ready handshake.
//  Drives the slice one 16-bit chunk per cycle, LSB chunk first, chaining
//  carry through a register. Returns the 64-bit result, carry-out and signed
//  overflow. Sits between the RISC-V ALU issue logic and the shared adder slice.
// PARAMETERS
//  WIDTH   64  operand/result width; must be an integer multiple of SLICE
//  SLICE   16  width of the external adder slice
//  NBEATS  WIDTH/SLICE (localparam, 4 by default)  beats per operation
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      sequencer can accept a request (IDLE only)
//  A          in   WIDTH  operand A, sampled on accept
//  B          in   WIDTH  operand B, sampled on accept
//  Sub        in   1      1 = A-B, 0 = A+B; sampled on accept
//  slice_A    out  SLICE  to adder slice A input
//  slice_B    out  SLICE  to adder slice B input (already inverted for Sub)
//  slice_Cin  out  1      to adder slice Cin
//  slice_S    in   SLICE  from adder slice sum
//  slice_Cout in   1      from adder slice carry-out
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  S          out  WIDTH  result
//  Cout       out  1      final carry-out (Sub: 1 = no borrow)
//  Ovf        out  1      signed two's-complement overflow
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. On rst_n=0: state=IDLE,
//    beat=0, carry=0, in_ready=1, out_valid=0, busy=0, S=0, Cout=0, Ovf=0,
//    slice_A/slice_B/slice_Cin=0. Reset mid-operation aborts it; no output.
//  - States: IDLE -> RUN on in_valid&in_ready; RUN -> DONE after beat NBEATS-1;
//    DONE -> IDLE on out_ready. in_ready=1 only in IDLE (no overlap/bypass).
//  - Accept: latch A_r=A, B_r=Sub ? ~B : B, carry=Sub, beat=0, ops sampled
//    once; later changes on A/B/Sub ignored until next accept.
//  - RUN beat k: slice_A=A_r[k*SLICE+:SLICE], slice_B=B_r[same], slice_Cin=
//    carry (registered outputs valid whole cycle). At edge: S[k chunk]<=slice_S,
//    carry<=slice_Cout, beat<=k+1. Slice outputs sampled same cycle (comb path).
//  - Latency: accept edge T -> out_valid=1 from edge T+NBEATS (4 cycles).
//  - DONE: out_valid=1; S, Cout(=final carry), Ovf held stable until
//    out_valid&out_ready; that edge returns to IDLE, out_valid=0; S/Cout/Ovf
//    keep last values. out_ready while not out_valid ignored.
//  - Ovf = (A_r[W-1]==B_r[W-1]) & (S[W-1]!=A_r[W-1]), computed at last beat.
//  - Arithmetic is modulo 2^WIDTH; wrap-around is not an error.
//  - Outside RUN, slice_* hold their last driven values (don't-care to slice).
//  - in_valid during RUN/DONE: ignored, requester must hold (in_ready=0).
// TESTING
//  1 Reset: rst_n=0 -> in_ready=1,out_valid=0,busy=0,S=0; release, idle 5 cyc.
//  2 Add 0x0000_0000_FFFF_FFFF+1 -> S=0x0000_0001_0000_0000,Cout=0,Ovf=0,
//    out_valid exactly 4 cycles after accept; carry ripples across chunks.
//  3 Sub 5-7 -> S=0xFFFF_FFFF_FFFF_FFFE,Cout=0; Sub 7-5 -> S=2,Cout=1.
//  4 Add 0x7FFF_FFFF_FFFF_FFFF+1 -> S=0x8000_0000_0000_0000,Ovf=1;
//    all-ones+1 -> S=0,Cout=1,Ovf=0.
//  5 Backpressure: out_ready=0 for 10 cycles -> S stable, in_ready=0, new
//    in_valid ignored; out_ready=1 -> IDLE next edge, next op accepted.
//  6 Assert rst_n=0 at beat 2 -> outputs to reset values immediately;
//    after release next op returns correct result.

Source files
------------

// File: rtl/add64_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract sequencer that time-shares one external
// SLICE-bit combinational adder, LSB chunk first, with a registered carry chain.
module add64_slice_sequencer #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   output logic [SLICE-1:0] slice_A,
   output logic [SLICE-1:0] slice_B,
   output logic             slice_Cin,
   input  logic [SLICE-1:0] slice_S,
   input  logic             slice_Cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             busy
);
   localparam int NBEATS = WIDTH / SLICE;
   localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [BW-1:0]    beat_q, beat_d, beat_nxt;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, b_in;
   logic             cout_q, cout_d, ovf_q, ovf_d;
   logic [SLICE-1:0] sa_q, sa_d, sb_q, sb_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         sa_q    <= '0;
         sb_q    <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      beat_nxt = beat_q + 1'b1;
      b_in     = Sub ? ~B : B;
      case (state_q)
         IDLE: begin
            // Subtract is A + ~B + 1: invert once here and seed carry with Sub.
            if (in_valid) begin
               state_d = RUN;
               a_d     = A;
               b_d     = b_in;
               carry_d = Sub;
               beat_d  = '0;
               sa_d    = A[SLICE-1:0];
               sb_d    = b_in[SLICE-1:0];
            end
         end
         RUN: begin
            s_d[beat_q*SLICE +: SLICE] = slice_S;
            if (beat_q == LAST_BEAT) begin
               state_d = DONE;
               beat_d  = '0;
               cout_d  = slice_Cout;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (slice_S[SLICE-1] != a_q[WIDTH-1]);
            end else begin
               // Present the next chunk so the slice sees it for a full cycle.
               beat_d  = beat_nxt;
               carry_d = slice_Cout;
               sa_d    = a_q[beat_nxt*SLICE +: SLICE];
               sb_d    = b_q[beat_nxt*SLICE +: SLICE];
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign slice_A   = sa_q;
   assign slice_B   = sb_q;
   assign slice_Cin = carry_q;
   assign S         = s_q;
   assign Cout      = cout_q;
   assign Ovf       = ovf_q;

endmodule

// File: tb/tb_add64_slice_sequencer.sv
// Scoreboard bench: a 16-bit adder slice model feeds the DUT; expected results
// come from whole-word arithmetic and are checked by an independent monitor.
module tb_add64_slice_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, Sub = 1'b0, out_ready = 1'b1;
   logic [63:0] A = '0, B = '0;
   logic        in_ready, slice_Cin, slice_Cout, out_valid, Cout, Ovf, busy;
   logic [15:0] slice_A, slice_B, slice_S;
   logic [63:0] S;

   add64_slice_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Sub(Sub), .slice_A(slice_A), .slice_B(slice_B),
      .slice_Cin(slice_Cin), .slice_S(slice_S), .slice_Cout(slice_Cout),
      .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout),
      .Ovf(Ovf), .busy(busy)
   );

   always #5 clk = ~clk;
   assign {slice_Cout, slice_S} = 17'(slice_A) + 17'(slice_B) + 17'(slice_Cin);

   typedef struct {logic [63:0] s; logic c; logic o; int acc;} exp_t;
   exp_t q[$];
   int   checks = 0, errors = 0, cyc = 0;
   bit   rand_rdy = 0, ov_prev = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
      exp_t e;
      e.s = s; e.c = c; e.o = o; e.acc = 0;
      return e;
   endfunction

   // Whole-word reference: unsigned carry/borrow and signed range check.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
      logic signed [64:0] r;
      logic [64:0]        u;
      r = sub ? ($signed({a[63], a}) - $signed({b[63], b}))
              : ($signed({a[63], a}) + $signed({b[63], b}));
      u = 65'(a) + 65'(b);
      return mk(sub ? a - b : a + b, sub ? (a >= b) : u[64], r[64] != r[63]);
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0: return 64'h0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h8000_0000_0000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub, input exp_t e);
      int n = 0;
      A = a; B = b; Sub = sub; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout actual=in_ready 0 required=1");
      end else begin
         e.acc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; A = {$urandom, $urandom}; B = {$urandom, $urandom}; Sub = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   // Monitor: latency on each out_valid rise, result on each handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) ov_prev = 1'b0;
      else begin
         if (out_valid && !ov_prev) begin
            if (q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
            else chk("latency", 64'(cyc - q[0].acc), 64'd4);
         end
         if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("S", S, e.s);
            chk("Cout", 64'(Cout), 64'(e.c));
            chk("Ovf", 64'(Ovf), 64'(e.o));
         end
         ov_prev = out_valid;
      end
   end

   always @(posedge clk) if (rand_rdy) begin #1 out_ready = 1'($urandom_range(0, 1)); end

   initial begin
      logic [63:0] saved, a, b;
      logic        s;
      int          n;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_S", S, 64'd0);
      chk("rst_CoutOvf", {62'd0, Cout, Ovf}, 64'd0);
      chk("rst_slice", {31'd0, slice_A, slice_B, slice_Cin}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;

      issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, mk(64'h0000_0001_0000_0000, 1'b0, 1'b0));
      @(negedge clk);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_in_ready", 64'(in_ready), 64'd0);
      issue(64'd5, 64'd7, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
      issue(64'd7, 64'd5, 1'b1, mk(64'd2, 1'b1, 1'b0));
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'd0, 1'b1, 1'b0));
      drain();

      // Backpressure with a competing request held on the input.
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
            model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0));
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      saved = S;
      A = 64'h8000_0000_0000_0001; B = 64'h0000_0000_0000_0003; Sub = 1'b1; in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("bp_S_stable", S, saved);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
      chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
      begin
         exp_t e;
         e = model(64'h8000_0000_0000_0001, 64'd3, 1'b1);
         e.acc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Abort in beat 2, then confirm a clean op afterwards.
      @(posedge clk); #1;
      issue(64'hDEAD_BEEF_0000_FFFF, 64'h1111_2222_FFFF_0001, 1'b0, mk(64'd0, 1'b0, 1'b0));
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0; #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_S", S, 64'd0);
      chk("abort_slice", {31'd0, slice_A, slice_B, slice_Cin}, 64'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1,
            model(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1));
      drain();

      rand_rdy = 1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         a = pick(); b = pick(); s = 1'($urandom);
         issue(a, b, s, model(a, b, s));
      end
      drain();
      rand_rdy = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
